// File: rtl/bp_table_ctrl.sv
// Branch-predictor table write-port controller: post-reset/flush clear sequencer plus
// single-entry update register. Optional flush counter under `BP_FLUSH_COUNT_EN.
module bp_table_ctrl #(
    parameter int ENTRIES = 512,
    parameter int WAYS    = 2,
    localparam int ADDR_W = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_req,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [WAYS-1:0]   upd_way,
    output logic              upd_accept,
    output logic              upd_dropped,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WAYS-1:0]   wr_way,
    output logic              wr_clear,
`ifdef BP_FLUSH_COUNT_EN
    output logic [15:0]       flush_count,
`endif
    output logic              bp_ready
);

    // Handshake: an update is taken on any cycle where upd_valid and upd_accept are both
    // high; upd_valid without upd_accept is discarded (never stalled) and flagged a cycle later.

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              uq_valid;
    logic [ADDR_W-1:0] uq_addr;
    logic [WAYS-1:0]   uq_way;

    assign upd_accept = ~rst & (state == IDLE) & upd_valid & ~flush_req;
    assign bp_ready   = ~rst & (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            idx         <= '0;
            uq_valid    <= 1'b0;
            upd_dropped <= 1'b0;
        end else begin
            upd_dropped <= upd_valid & ~upd_accept;
            // A flush blocks acceptance, so this also kills the pending entry.
            uq_valid    <= upd_accept;
            if (upd_accept) begin
                uq_addr <= upd_addr;
                uq_way  <= upd_way;
            end
            if (flush_req) begin
                state <= CLEAR;
                idx   <= '0;
            end else if (state == CLEAR) begin
                if (idx == LAST_IDX) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_clear = 1'b0;
        wr_addr  = '0;
        wr_way   = '0;
        if (state == CLEAR) begin
            wr_en    = 1'b1;
            wr_clear = 1'b1;
            wr_addr  = idx;
            wr_way   = '1;
        end else if (!rst && uq_valid) begin
            wr_en   = 1'b1;
            wr_addr = uq_addr;
            wr_way  = uq_way;
        end
    end

`ifdef BP_FLUSH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count <= '0;
        end else if (flush_req && flush_count != 16'hFFFF) begin
            flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl (ENTRIES=8, WAYS=2): countdown-based reference model checked on
// every negedge, plus directed literal checks. Exercises flush_count when BP_FLUSH_COUNT_EN is set.
module tb_bp_table_ctrl;
    localparam int ENTRIES = 8;
    localparam int WAYS    = 2;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_req = 1'b0;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic [WAYS-1:0] upd_way = '0;
    logic          upd_accept, upd_dropped, wr_en, wr_clear, bp_ready;
    logic [AW-1:0] wr_addr;
    logic [WAYS-1:0] wr_way;
`ifdef BP_FLUSH_COUNT_EN
    logic [15:0]   flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bp_table_ctrl #(.ENTRIES(ENTRIES), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_way(upd_way),
        .upd_accept(upd_accept), .upd_dropped(upd_dropped),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_way(wr_way), .wr_clear(wr_clear),
`ifdef BP_FLUSH_COUNT_EN
        .flush_count(flush_count),
`endif
        .bp_ready(bp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: clear_left counts remaining clear cycles (0 = table usable).
    bit          m_valid = 0;
    int          clear_left = 0;
    bit          m_pend = 0;
    int          m_pend_addr = 0;
    int          m_pend_way = 0;
    bit          m_dropped = 0;
    int          m_fcount = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_valid    = 1;
            clear_left = ENTRIES;
            m_pend     = 0;
            m_dropped  = 0;
            m_fcount   = 0;
        end else begin
            acc       = (clear_left == 0) && upd_valid && !flush_req;
            m_dropped = upd_valid && !acc;
            if (flush_req && m_fcount < 65535) m_fcount++;
            if (flush_req) begin
                clear_left = ENTRIES;
                m_pend     = 0;
            end else if (clear_left > 0) begin
                clear_left--;
                m_pend = 0;
            end else begin
                m_pend = acc;
                if (acc) begin
                    m_pend_addr = upd_addr;
                    m_pend_way  = upd_way;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_dropped", upd_dropped, m_dropped);
            if (clear_left > 0) begin
                chk("m_clr_en", wr_en, 1);
                chk("m_clr_clear", wr_clear, 1);
                chk("m_clr_way", wr_way, 3);
                chk("m_clr_addr", wr_addr, ENTRIES - clear_left);
                chk("m_clr_ready", bp_ready, 0);
                chk("m_clr_accept", upd_accept, 0);
            end else if (rst) begin
                chk("m_rst_en", wr_en, 0);
                chk("m_rst_ready", bp_ready, 0);
                chk("m_rst_accept", upd_accept, 0);
            end else begin
                chk("m_idle_ready", bp_ready, 1);
                chk("m_idle_accept", upd_accept, int'(upd_valid && !flush_req));
                chk("m_idle_en", wr_en, m_pend);
                chk("m_idle_clear", wr_clear, 0);
                chk("m_idle_way", wr_way, m_pend ? m_pend_way : 0);
                if (m_pend) chk("m_idle_addr", wr_addr, m_pend_addr);
            end
`ifdef BP_FLUSH_COUNT_EN
            chk("m_fcount", flush_count, m_fcount);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        // Post-reset clear: addresses 0..7, then ready.
        for (int i = 0; i < ENTRIES; i++) begin
            chk("clr_addr", wr_addr, i);
            chk("clr_ready", bp_ready, 0);
            tick();
        end
        chk("idle_ready", bp_ready, 1);
        chk("idle_wr_en", wr_en, 0);

        // Single update, 1-cycle latency.
        upd_valid = 1'b1; upd_addr = 3'd5; upd_way = 2'b10;
        #1 chk("upd_accept", upd_accept, 1);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("upd_wr_en", wr_en, 1);
        chk("upd_wr_clear", wr_clear, 0);
        chk("upd_wr_addr", wr_addr, 5);
        chk("upd_wr_way", wr_way, 2);
        tick();

        // Back-to-back updates 1,2,3.
        for (int a = 1; a <= 3; a++) begin
            upd_valid = 1'b1; upd_addr = AW'(a); upd_way = 2'b01;
            tick();
            chk("b2b_wr_addr", wr_addr, a);
        end
        upd_valid = 1'b0;
        tick();
        chk("b2b_done_en", wr_en, 0);

        // Flush and update together: flush wins.
        flush_req = 1'b1; upd_valid = 1'b1; upd_addr = 3'd6;
        #1 chk("fl_accept", upd_accept, 0);
        tick();
        flush_req = 1'b0; upd_valid = 1'b0;
        #1;
        chk("fl_dropped", upd_dropped, 1);
        chk("fl_ready", bp_ready, 0);
        chk("fl_addr", wr_addr, 0);
        chk("fl_clear", wr_clear, 1);

        // Flush at clear idx 5 restarts the clear.
        repeat (5) tick();
        chk("idx5_addr", wr_addr, 5);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("restart_addr", wr_addr, 0);
        for (int i = 0; i < ENTRIES; i++) begin
            chk("restart_ready", bp_ready, 0);
            tick();
        end
        chk("restart_done", bp_ready, 1);

        // Update held across a whole clear: every one dropped.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b1; upd_addr = 3'd2; upd_way = 2'b11;
        for (int i = 0; i < ENTRIES; i++) begin
            chk("hold_accept", upd_accept, 0);
            tick();
        end
        upd_valid = 1'b0;
        #1 chk("hold_dropped", upd_dropped, 1);
        tick();

`ifdef BP_FLUSH_COUNT_EN
        chk("fcount_3", flush_count, 3);
`endif

        // Reset in the middle of a clear restarts at 0.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_addr", wr_addr, 0);
`ifdef BP_FLUSH_COUNT_EN
        chk("fcount_rst", flush_count, 0);
        flush_req = 1'b1;
        repeat (65537) tick();
        flush_req = 1'b0;
        chk("fcount_sat", flush_count, 16'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fcount_rst2", flush_count, 0);
`endif
        repeat (ENTRIES + 2) tick();
        chk("final_ready", bp_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
